// File: rtl/register_status_table.sv
// rtl/register_status_table.sv - Tomasulo register result-status table
// Tracks the pending producer tag per architectural register; queries bypass the write bus.
module register_status_table #(
  parameter int RegCount    = 16,
  parameter int RegSelWidth = 4,
  parameter int TagWidth    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [RegSelWidth-1:0] in_LeftQueryRegister,
  output logic                   out_LeftReadBusOpen,
  output logic [TagWidth-1:0]    out_LeftComponentEntry,
  input  logic [RegSelWidth-1:0] in_RightQueryRegister,
  output logic                   out_RightReadBusOpen,
  output logic [TagWidth-1:0]    out_RightComponentEntry,
  input  logic                   in_AllocEnable,
  input  logic [RegSelWidth-1:0] in_AllocRegister,
  input  logic [TagWidth-1:0]    in_AllocTag,
  input  logic                   in_WriteEnable,
  input  logic [RegSelWidth-1:0] in_WriteRegister,
  input  logic [TagWidth-1:0]    in_WriteTag,
  input  logic                   in_Flush,
  output logic [RegSelWidth:0]   out_PendingCount
);

  localparam logic [RegSelWidth:0] CntOne = 1;

  logic [RegCount-1:0] valid_q, valid_d;
  logic [TagWidth-1:0] tag_q [RegCount];
  logic [TagWidth-1:0] tag_d [RegCount];
  logic [RegSelWidth:0] count_q, count_d;

  logic write_hit;

  // A broadcast retires a record only if it still names the youngest producer.
  assign write_hit = in_WriteEnable && valid_q[in_WriteRegister] &&
                     (tag_q[in_WriteRegister] == in_WriteTag);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (write_hit) begin
      valid_d[in_WriteRegister] = 1'b0;
      tag_d[in_WriteRegister]   = '0;
    end
    // Alloc is applied after retire so a same-register collision leaves the new producer.
    if (in_AllocEnable) begin
      valid_d[in_AllocRegister] = 1'b1;
      tag_d[in_AllocRegister]   = in_AllocTag;
    end
    if (in_Flush) begin
      valid_d = '0;
      for (int i = 0; i < RegCount; i++) begin
        tag_d[i] = '0;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < RegCount; i++) begin
      if (valid_d[i]) begin
        count_d = count_d + CntOne;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < RegCount; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < RegCount; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  logic left_bypass, right_bypass;

  // Sources see state before this cycle's alloc, plus the completing write on the bus.
  assign left_bypass  = in_WriteEnable && (in_WriteRegister == in_LeftQueryRegister) &&
                        (in_WriteTag == tag_q[in_LeftQueryRegister]);
  assign right_bypass = in_WriteEnable && (in_WriteRegister == in_RightQueryRegister) &&
                        (in_WriteTag == tag_q[in_RightQueryRegister]);

  always_comb begin
    out_LeftReadBusOpen     = !valid_q[in_LeftQueryRegister] || left_bypass;
    out_RightReadBusOpen    = !valid_q[in_RightQueryRegister] || right_bypass;
    out_LeftComponentEntry  = out_LeftReadBusOpen  ? '0 : tag_q[in_LeftQueryRegister];
    out_RightComponentEntry = out_RightReadBusOpen ? '0 : tag_q[in_RightQueryRegister];
  end

  assign out_PendingCount = count_q;

endmodule

// File: tb/tb_register_status_table.sv
// tb/tb_register_status_table.sv - self-checking bench for register_status_table
// Scoreboard of pending records checked every cycle, plus directed literal checks.
module tb_register_status_table;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] lq, rq, ar, wr;
  logic [7:0] atag, wtag;
  logic       aen, wen, flush;
  logic       l_open, r_open;
  logic [7:0] l_ent, r_ent;
  logic [4:0] cnt;

  int checks = 0;
  int fails  = 0;
  bit check_en = 0;

  logic       m_valid [16];
  logic [7:0] m_tag   [16];

  register_status_table dut (
    .clock(clock), .reset(reset),
    .in_LeftQueryRegister(lq), .out_LeftReadBusOpen(l_open), .out_LeftComponentEntry(l_ent),
    .in_RightQueryRegister(rq), .out_RightReadBusOpen(r_open), .out_RightComponentEntry(r_ent),
    .in_AllocEnable(aen), .in_AllocRegister(ar), .in_AllocTag(atag),
    .in_WriteEnable(wen), .in_WriteRegister(wr), .in_WriteTag(wtag),
    .in_Flush(flush), .out_PendingCount(cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the set of registers awaiting a result and who produces each.
  always @(posedge clock or negedge reset) begin
    if (!reset || flush) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_tag[i] = 0; end
    end else begin
      if (wen && m_valid[wr] && m_tag[wr] == wtag) begin
        m_valid[wr] = 0; m_tag[wr] = 0;
      end
      if (aen) begin m_valid[ar] = 1; m_tag[ar] = atag; end
    end
  end

  function automatic logic exp_open(input logic [3:0] q);
    return !m_valid[q] || (wen && wr == q && wtag == m_tag[q]);
  endfunction

  function automatic logic [4:0] exp_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_valid[i]);
    return 5'(n);
  endfunction

  always @(negedge clock) begin
    if (check_en && reset) begin
      check("model_l_open", {31'd0, l_open}, {31'd0, exp_open(lq)});
      check("model_r_open", {31'd0, r_open}, {31'd0, exp_open(rq)});
      check("model_l_ent", {24'd0, l_ent}, exp_open(lq) ? 32'd0 : {24'd0, m_tag[lq]});
      check("model_r_ent", {24'd0, r_ent}, exp_open(rq) ? 32'd0 : {24'd0, m_tag[rq]});
      check("model_count", {27'd0, cnt}, {27'd0, exp_count()});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic alloc(input logic [3:0] r, input logic [7:0] t);
    aen = 1; ar = r; atag = t;
  endtask

  task automatic bus(input logic [3:0] r, input logic [7:0] t);
    wen = 1; wr = r; wtag = t;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_tag[i] = 0; end
    reset = 0; lq = 0; rq = 0; ar = 0; wr = 0; atag = 0; wtag = 0;
    aen = 0; wen = 0; flush = 0;
    #2;
    check("reset_open", {31'd0, l_open}, 32'd1);
    check("reset_count", {27'd0, cnt}, 32'd0);
    #10 reset = 1;
    check_en = 1;

    // Alloc then query
    step(); alloc(4'd2, 8'h11);
    step(); aen = 0; lq = 2; rq = 2; #1;
    check("alloc_l_open", {31'd0, l_open}, 32'd0);
    check("alloc_l_ent", {24'd0, l_ent}, 32'h11);
    check("alloc_r_ent", {24'd0, r_ent}, 32'h11);
    check("alloc_count", {27'd0, cnt}, 32'd1);
    rq = 5; #1;
    check("r5_open", {31'd0, r_open}, 32'd1);
    check("r5_ent", {24'd0, r_ent}, 32'd0);

    // Retire with bypass
    bus(4'd2, 8'h11); #1;
    check("bypass_open", {31'd0, l_open}, 32'd1);
    check("bypass_ent", {24'd0, l_ent}, 32'd0);
    step(); wen = 0; #1;
    check("retire_open", {31'd0, l_open}, 32'd1);
    check("retire_count", {27'd0, cnt}, 32'd0);

    // Stale tag (WAW)
    alloc(4'd4, 8'h09);
    step(); alloc(4'd4, 8'h0A);
    step(); aen = 0; lq = 4; bus(4'd4, 8'h09); #1;
    check("stale_open", {31'd0, l_open}, 32'd0);
    check("stale_ent", {24'd0, l_ent}, 32'h0A);
    step(); wen = 0; #1;
    check("stale_kept", {24'd0, l_ent}, 32'h0A);
    check("stale_count", {27'd0, cnt}, 32'd1);
    bus(4'd4, 8'h0A);
    step(); wen = 0; #1;
    check("waw_cleared", {31'd0, l_open}, 32'd1);
    check("waw_count", {27'd0, cnt}, 32'd0);

    // Same-cycle alloc and write on one register
    alloc(4'd7, 8'h01);
    step(); alloc(4'd7, 8'h12); bus(4'd7, 8'h01); lq = 7; #1;
    check("same_bypass", {31'd0, l_open}, 32'd1);
    check("same_count0", {27'd0, cnt}, 32'd1);
    step(); aen = 0; wen = 0; #1;
    check("same_open", {31'd0, l_open}, 32'd0);
    check("same_ent", {24'd0, l_ent}, 32'h12);
    check("same_count", {27'd0, cnt}, 32'd1);

    // Flush precedence
    alloc(4'd1, 8'h05);
    step(); alloc(4'd3, 8'h06);
    step(); aen = 0; #1;
    check("pre_flush_count", {27'd0, cnt}, 32'd3);
    flush = 1; alloc(4'd1, 8'h20);
    step(); flush = 0; aen = 0; #1;
    check("flush_count", {27'd0, cnt}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      lq = 4'(i); #1;
      check("flush_open", {31'd0, l_open}, 32'd1);
    end

    // Fill every register: count must reach 16 without wrapping
    for (int i = 0; i < 16; i++) begin
      alloc(4'(i), 8'(8'h40 + i));
      step();
    end
    aen = 0; #1;
    check("full_count", {27'd0, cnt}, 32'd16);
    lq = 15; rq = 0; #1;
    check("full_ent15", {24'd0, l_ent}, 32'h4F);
    check("full_ent0", {24'd0, r_ent}, 32'h40);
    for (int i = 0; i < 16; i += 2) begin
      bus(4'(i), 8'(8'h40 + i));
      step();
    end
    wen = 0; #1;
    check("half_count", {27'd0, cnt}, 32'd8);
    // Write to a non-pending register is ignored
    bus(4'd0, 8'h00);
    step(); wen = 0; #1;
    check("idle_write_count", {27'd0, cnt}, 32'd8);
    flush = 1;
    step(); flush = 0;

    // Asynchronous reset mid-cycle with R3 pending
    alloc(4'd3, 8'h33);
    step(); aen = 0; lq = 3; rq = 3; #1;
    check("r3_pending", {24'd0, l_ent}, 32'h33);
    reset = 0; #1;
    check("areset_l_open", {31'd0, l_open}, 32'd1);
    check("areset_r_ent", {24'd0, r_ent}, 32'd0);
    check("areset_count", {27'd0, cnt}, 32'd0);
    step(); step();
    reset = 1;
    step(); #1;
    check("post_reset_open", {31'd0, l_open}, 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
